// File: rtl/layer_collector.sv
// Collects per-lane neuron outputs into one packed vector, emitting it with a
// one-cycle valid once every lane has reported; flags duplicates and timeouts.
module layer_collector #(
    parameter int numNeuron     = 10,
    parameter int dataWidth     = 16,
    parameter int timeoutCycles = 0
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [numNeuron*dataWidth-1:0] neuronData,
    input  logic [numNeuron-1:0]           neuronValid,
    input  logic                           clearErr,
    output logic [numNeuron*dataWidth-1:0] outData,
    output logic                           outValid,
    output logic                           busy,
    output logic                           dupErr,
    output logic                           toErr
);

    localparam int LW = numNeuron * dataWidth;
    localparam bit TO_EN = (timeoutCycles > 0);
    localparam int CW = TO_EN ? $clog2(timeoutCycles + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TO_EN ? timeoutCycles - 1 : 0);

    typedef enum logic [0:0] {IDLE, COLLECT} state_t;

    state_t               state_q, state_d;
    logic [LW-1:0]        buf_q, buf_d;
    logic [numNeuron-1:0] mask_q, mask_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [LW-1:0]        outData_q, outData_d;
    logic                 outValid_q, outValid_d;
    logic                 busy_q, busy_d;
    logic                 dupErr_q, dupErr_d;
    logic                 toErr_q, toErr_d;

    logic [numNeuron-1:0] accept;
    logic [numNeuron-1:0] merged_mask;
    logic [LW-1:0]        merged_buf;
    logic                 complete;
    logic                 timeout_hit;

    always_comb begin
        accept      = neuronValid & ~mask_q;
        merged_mask = mask_q | accept;
        merged_buf  = buf_q;
        for (int unsigned i = 0; i < numNeuron; i++) begin
            if (accept[i]) begin
                merged_buf[i*dataWidth +: dataWidth] = neuronData[i*dataWidth +: dataWidth];
            end
        end
        complete    = &merged_mask;
        // Completion on the timeout edge wins, so the timeout is masked by it.
        timeout_hit = TO_EN && (state_q == COLLECT) && (cnt_q == TO_LAST) && !complete;

        outData_d  = outData_q;
        outValid_d = 1'b0;
        buf_d      = merged_buf;
        mask_d     = merged_mask;
        state_d    = (|merged_mask) ? COLLECT : IDLE;
        dupErr_d   = (dupErr_q & ~clearErr) | (|(neuronValid & mask_q));
        toErr_d    = (toErr_q & ~clearErr) | timeout_hit;

        if (complete) begin
            outData_d  = merged_buf;
            outValid_d = 1'b1;
            mask_d     = '0;
            state_d    = IDLE;
        end else if (timeout_hit) begin
            buf_d   = buf_q;
            mask_d  = '0;
            state_d = IDLE;
        end

        if (!TO_EN || state_q == IDLE) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        busy_d = (state_d == COLLECT);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            buf_q      <= '0;
            mask_q     <= '0;
            cnt_q      <= '0;
            outData_q  <= '0;
            outValid_q <= 1'b0;
            busy_q     <= 1'b0;
            dupErr_q   <= 1'b0;
            toErr_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            mask_q     <= mask_d;
            cnt_q      <= cnt_d;
            outData_q  <= outData_d;
            outValid_q <= outValid_d;
            busy_q     <= busy_d;
            dupErr_q   <= dupErr_d;
            toErr_q    <= toErr_d;
        end
    end

    assign outData  = outData_q;
    assign outValid = outValid_q;
    assign busy     = busy_q;
    assign dupErr   = dupErr_q;
    assign toErr    = toErr_q;

endmodule

// File: tb/tb_layer_collector.sv
// Directed and randomized bench for layer_collector against a lane-set model.
module tb_layer_collector;

    localparam int N  = 10;
    localparam int W  = 16;
    localparam int TO = 20;

    logic           clk = 1'b0;
    logic           rstn;
    logic [N*W-1:0] neuronData;
    logic [N-1:0]   neuronValid;
    logic           clearErr;
    logic [N*W-1:0] outData;
    logic           outValid;
    logic           busy;
    logic           dupErr;
    logic           toErr;

    always #5 clk = ~clk;

    layer_collector #(
        .numNeuron(N),
        .dataWidth(W),
        .timeoutCycles(TO)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .neuronData(neuronData),
        .neuronValid(neuronValid),
        .clearErr(clearErr),
        .outData(outData),
        .outValid(outValid),
        .busy(busy),
        .dupErr(dupErr),
        .toErr(toErr)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: which lanes are held, their values, and when the set began.
    bit             have[N];
    logic [W-1:0]   val[N];
    logic [N*W-1:0] e_data;
    bit             e_valid, e_busy, e_dup, e_to;
    int             cyc;
    int             first_cyc;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            have[i] = 1'b0;
            val[i]  = '0;
        end
        e_data  = '0;
        e_valid = 1'b0;
        e_busy  = 1'b0;
        e_dup   = 1'b0;
        e_to    = 1'b0;
    endtask

    task automatic model_edge(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic clr);
        int  held = 0;
        bit  dup_now = 1'b0;
        bit  all_in = 1'b1;
        bit  to_now = 1'b0;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (have[i]) held++;
            if (v[i] && have[i]) dup_now = 1'b1;
            if (!(have[i] || v[i])) all_in = 1'b0;
        end
        e_valid = 1'b0;
        if (all_in) begin
            for (int i = 0; i < N; i++) begin
                if (!have[i]) val[i] = d[i*W +: W];
                e_data[i*W +: W] = val[i];
                have[i] = 1'b0;
            end
            e_valid = 1'b1;
        end else if (held > 0 && (cyc - first_cyc) == TO) begin
            for (int i = 0; i < N; i++) have[i] = 1'b0;
            to_now = 1'b1;
        end else begin
            if (held == 0 && v != '0) first_cyc = cyc;
            for (int i = 0; i < N; i++) begin
                if (v[i] && !have[i]) begin
                    have[i] = 1'b1;
                    val[i]  = d[i*W +: W];
                end
            end
        end
        e_dup  = (e_dup && !clr) || dup_now;
        e_to   = (e_to && !clr) || to_now;
        e_busy = 1'b0;
        for (int i = 0; i < N; i++) if (have[i]) e_busy = 1'b1;
    endtask

    task automatic chk(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".outData"},  outData, e_data);
        chk({tag, ".outValid"}, {{(N*W-1){1'b0}}, outValid}, {{(N*W-1){1'b0}}, e_valid});
        chk({tag, ".busy"},     {{(N*W-1){1'b0}}, busy},     {{(N*W-1){1'b0}}, e_busy});
        chk({tag, ".dupErr"},   {{(N*W-1){1'b0}}, dupErr},   {{(N*W-1){1'b0}}, e_dup});
        chk({tag, ".toErr"},    {{(N*W-1){1'b0}}, toErr},    {{(N*W-1){1'b0}}, e_to});
    endtask

    task automatic step(input string tag, input logic [N-1:0] v, input logic [N*W-1:0] d,
                        input logic clr);
        neuronValid = v;
        neuronData  = d;
        clearErr    = clr;
        @(posedge clk);
        model_edge(v, d, clr);
        #1;
        check_all(tag);
        neuronValid = '0;
        clearErr    = 1'b0;
    endtask

    function automatic logic [N*W-1:0] lanes(input int base, input int mult);
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = W'(base + i * mult);
        return r;
    endfunction

    function automatic logic [N*W-1:0] rand_data();
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = W'($urandom);
        return r;
    endfunction

    initial begin
        logic [N*W-1:0] d;
        logic [N-1:0]   v;

        cyc = 0;
        first_cyc = 0;
        rstn = 1'b0;
        neuronValid = '0;
        neuronData = '0;
        clearErr = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        rstn = 1'b1;

        // 1: full set in one cycle
        step("t1_load", '1, lanes(0, 100), 1'b0);
        chk("t1_valid", {{(N*W-1){1'b0}}, outValid}, {{(N*W-1){1'b0}}, 1'b1});
        step("t1_after", '0, '0, 1'b0);

        // 2: one lane per cycle, 9 down to 0
        d = lanes(16'h1000, 7);
        for (int i = N - 1; i >= 0; i--) begin
            v = '0;
            v[i] = 1'b1;
            step("t2_lane", v, d, 1'b0);
        end
        chk("t2_data", outData, lanes(16'h1000, 7));
        step("t2_after", '0, '0, 1'b0);

        // 6: back-to-back full sets
        step("t6_a", '1, lanes(16'h2000, 3), 1'b0);
        step("t6_b", '1, lanes(16'h3000, 5), 1'b0);
        chk("t6_data", outData, lanes(16'h3000, 5));
        step("t6_after", '0, '0, 1'b0);

        // 3: duplicate on lane 3 keeps first value
        d = '0;
        d[3*W +: W] = 16'h0AAA;
        step("t3_first", 10'b00_0000_1000, d, 1'b0);
        d[3*W +: W] = 16'h0BBB;
        step("t3_dup", 10'b00_0000_1000, d, 1'b0);
        chk("t3_dupErr", {{(N*W-1){1'b0}}, dupErr}, {{(N*W-1){1'b0}}, 1'b1});
        step("t3_rest", 10'b11_1111_0111, lanes(16'h4000, 1), 1'b0);
        chk("t3_lane3", {{(N*W-W){1'b0}}, outData[3*W +: W]}, {{(N*W-W){1'b0}}, 16'h0AAA});
        step("t3_clear", '0, '0, 1'b1);

        // 4: timeout after 20 edges
        step("t4_part", 10'b00_0001_1111, lanes(16'h5000, 2), 1'b0);
        for (int k = 1; k <= TO; k++) step("t4_wait", '0, '0, 1'b0);
        chk("t4_toErr", {{(N*W-1){1'b0}}, toErr}, {{(N*W-1){1'b0}}, 1'b1});
        step("t4_full", '1, lanes(16'h6000, 9), 1'b0);
        step("t4_clear", '0, '0, 1'b1);

        // 5: asynchronous reset mid-set
        step("t5_part", 10'b00_0001_1111, lanes(16'h7000, 4), 1'b0);
        neuronValid = '1;
        neuronData  = lanes(16'h7100, 1);
        rstn = 1'b0;
        model_reset();
        #1;
        check_all("t5_rst");
        #3;
        rstn = 1'b1;
        step("t5_hi", 10'b11_1110_0000, lanes(16'h7200, 1), 1'b0);
        step("t5_lo", 10'b00_0001_1111, lanes(16'h7300, 1), 1'b0);
        step("t5_after", '0, '0, 1'b0);

        // randomized traffic with occasional quiet stretches to force timeouts
        for (int n = 0; n < 600; n++) begin
            if ((n % 150) > 125) v = '0;
            else if ($urandom_range(0, 19) == 0) v = '1;
            else if ($urandom_range(0, 9) < 3) v = '0;
            else v = N'($urandom & $urandom);
            step("rand", v, rand_data(), ($urandom_range(0, 15) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
